// File: rtl/gf2_skid_stage.sv
// -----------------------------------------------------------------------------
// gf2_skid_stage
//   Two-slot input buffer for one operand side of adder_gf2: a pass-through
//   path plus one skid register. The upstream producer sees a registered
//   ready. The join logic sees the side's current head operand and pulses
//   consume when that head is used.
//
// Ports
//   i_clock       rising-edge clock
//   i_reset       synchronous, active-high reset
//   i_in_data_i   upstream operand
//   i_in_valid_i  upstream operand valid
//   o_in_ready_o  upstream may transfer (registered, equals !skid_full)
//   o_head_data_o current head operand (skid register if full, else live input)
//   o_head_valid_o head operand is valid
//   i_consume_i   head is taken by the join this cycle
// -----------------------------------------------------------------------------
module gf2_skid_stage #(
  parameter int WIDTH = 16
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_in_data_i,
  input  logic             i_in_valid_i,
  output logic             o_in_ready_o,
  output logic [WIDTH-1:0] o_head_data_o,
  output logic             o_head_valid_o,
  input  logic             i_consume_i
);

  logic             ready_q, ready_d;
  logic             full_q, full_d;
  logic [WIDTH-1:0] skid_q;
  logic             in_xfer;
  logic             capture;

  // ready_q is !full_q outside reset, so a transfer never lands on a full skid.
  assign in_xfer        = i_in_valid_i && ready_q;
  assign capture        = in_xfer && !i_consume_i;

  assign o_in_ready_o   = ready_q;
  assign o_head_valid_o = full_q || in_xfer;
  assign o_head_data_o  = full_q ? skid_q : i_in_data_i;

  always_comb begin
    full_d = full_q;
    if (full_q && i_consume_i) begin
      full_d = 1'b0;
    end else if (capture) begin
      full_d = 1'b1;
    end
    ready_d = !full_d;
  end

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge values, independent of block ordering.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      full_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      full_q  <= full_d;
      ready_q <= ready_d;
    end
  end

  // NOTE: the skid data register has no reset; its contents are only ever
  // observed while full_q is set, and full_q itself is reset.
  always_ff @(posedge i_clock) begin
    if (capture) begin
      skid_q <= i_in_data_i;
    end
  end

endmodule

// File: rtl/adder_gf2.sv
// -----------------------------------------------------------------------------
// adder_gf2
//   Streaming GF(2) adder. Joins the lhs and rhs valid/ready operand streams,
//   pairing operands strictly in arrival order, and emits lhs XOR rhs on a
//   registered valid/ready result stream. Each side is buffered by its own
//   gf2_skid_stage so operands may arrive in different cycles.
//
// Ports
//   i_clock        rising-edge clock
//   i_reset        synchronous, active-high reset
//   i_lhs_data_i / i_lhs_valid_i / o_lhs_ready_o   left operand stream
//   i_rhs_data_i / i_rhs_valid_i / o_rhs_ready_o   right operand stream
//   o_sum_data_o / o_sum_valid_o / i_sum_ready_i   result stream (registered)
// -----------------------------------------------------------------------------
module adder_gf2 #(
  parameter int WIDTH = 16
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_lhs_data,
  input  logic             i_lhs_valid,
  output logic             o_lhs_ready,
  input  logic [WIDTH-1:0] i_rhs_data,
  input  logic             i_rhs_valid,
  output logic             o_rhs_ready,
  output logic [WIDTH-1:0] o_sum_data,
  output logic             o_sum_valid,
  input  logic             i_sum_ready
);

  logic [WIDTH-1:0] lhs_head_data, rhs_head_data;
  logic             lhs_head_valid, rhs_head_valid;
  logic             fire;

  logic [WIDTH-1:0] sum_data_q, sum_data_d;
  logic             sum_valid_q, sum_valid_d;

  gf2_skid_stage #(.WIDTH(WIDTH)) u_lhs_skid (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_in_data_i    (i_lhs_data),
    .i_in_valid_i   (i_lhs_valid),
    .o_in_ready_o   (o_lhs_ready),
    .o_head_data_o  (lhs_head_data),
    .o_head_valid_o (lhs_head_valid),
    .i_consume_i    (fire)
  );

  gf2_skid_stage #(.WIDTH(WIDTH)) u_rhs_skid (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_in_data_i    (i_rhs_data),
    .i_in_valid_i   (i_rhs_valid),
    .o_in_ready_o   (o_rhs_ready),
    .o_head_data_o  (rhs_head_data),
    .o_head_valid_o (rhs_head_valid),
    .i_consume_i    (fire)
  );

  // The output register may be reloaded in the same cycle its current
  // value is accepted, which keeps full throughput.
  assign fire = lhs_head_valid && rhs_head_valid && (!sum_valid_q || i_sum_ready);

  always_comb begin
    sum_data_d  = sum_data_q;
    sum_valid_d = sum_valid_q;
    if (fire) begin
      sum_data_d  = lhs_head_data ^ rhs_head_data;
      sum_valid_d = 1'b1;
    end else if (sum_valid_q && i_sum_ready) begin
      sum_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sum_data_q  <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      sum_data_q  <= sum_data_d;
      sum_valid_q <= sum_valid_d;
    end
  end

  assign o_sum_data  = sum_data_q;
  assign o_sum_valid = sum_valid_q;

endmodule

// File: tb/tb_adder_gf2.sv
// -----------------------------------------------------------------------------
// tb_adder_gf2
//   Self-checking bench for adder_gf2. A negedge monitor records every
//   operand transfer into per-side FIFOs; every result transfer must equal
//   the XOR of the oldest lhs and rhs operands not yet paired.
// -----------------------------------------------------------------------------
module tb_adder_gf2;

  localparam int W = 16;

  logic         i_clock = 1'b0;
  logic         i_reset = 1'b1;
  logic [W-1:0] i_lhs_data = '0;
  logic         i_lhs_valid = 1'b0;
  logic         o_lhs_ready;
  logic [W-1:0] i_rhs_data = '0;
  logic         i_rhs_valid = 1'b0;
  logic         o_rhs_ready;
  logic [W-1:0] o_sum_data;
  logic         o_sum_valid;
  logic         i_sum_ready = 1'b0;

  adder_gf2 #(.WIDTH(W)) dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_lhs_data  (i_lhs_data),
    .i_lhs_valid (i_lhs_valid),
    .o_lhs_ready (o_lhs_ready),
    .i_rhs_data  (i_rhs_data),
    .i_rhs_valid (i_rhs_valid),
    .o_rhs_ready (o_rhs_ready),
    .o_sum_data  (o_sum_data),
    .o_sum_valid (o_sum_valid),
    .i_sum_ready (i_sum_ready)
  );

  always #5 i_clock = ~i_clock;

  typedef enum {PH_OTHER, PH_IDLE, PH_STREAM} phase_e;

  int           n_vec  = 0;
  int           n_fail = 0;
  int           n_out  = 0;
  int           n_lacc = 0;
  int           n_racc = 0;
  logic [W-1:0] lq[$];
  logic [W-1:0] rq[$];
  phase_e       phase = PH_OTHER;
  bit           stream_drop = 1'b0;
  bit           idle_valid_seen = 1'b0;
  bit           l_x_last = 1'b0;
  bit           r_x_last = 1'b0;
  bit           prev_stall = 1'b0;
  logic [W-1:0] held = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: ordered operand FIFOs, pairing strictly by arrival.
  // Transfers are decided by the values present at the negedge, which the
  // drivers hold unchanged until the following posedge.
  always @(negedge i_clock) begin
    logic [W-1:0] a, b;
    if (i_reset) begin
      lq.delete();
      rq.delete();
      prev_stall = 1'b0;
      l_x_last   = 1'b0;
      r_x_last   = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(o_sum_valid), 32'd1);
        check("hold_data", 32'(o_sum_data), 32'(held));
      end
      if (o_sum_valid && i_sum_ready) begin
        n_out++;
        if (lq.size() == 0 || rq.size() == 0) begin
          check("orphan_sum", 32'd0, 32'd1);
        end else begin
          a = lq.pop_front();
          b = rq.pop_front();
          check("sum", 32'(o_sum_data), 32'(a ^ b));
        end
      end
      l_x_last = i_lhs_valid && o_lhs_ready;
      r_x_last = i_rhs_valid && o_rhs_ready;
      if (l_x_last) begin lq.push_back(i_lhs_data); n_lacc++; end
      if (r_x_last) begin rq.push_back(i_rhs_data); n_racc++; end
      prev_stall = o_sum_valid && !i_sum_ready;
      held       = o_sum_data;
      if (phase == PH_STREAM && !(o_lhs_ready && o_rhs_ready)) stream_drop = 1'b1;
      if (phase == PH_IDLE && o_sum_valid) idle_valid_seen = 1'b1;
    end
  end

  // Both push tasks start at posedge+1 and return at posedge+1 after the
  // edge on which the beat transferred.
  task automatic push_lhs(input logic [W-1:0] d, output int waited);
    waited = 0;
    i_lhs_data  = d;
    i_lhs_valid = 1'b1;
    @(negedge i_clock);
    while (!o_lhs_ready && waited < 500) begin
      waited++;
      @(negedge i_clock);
    end
    if (!o_lhs_ready) check("lhs_timeout", 32'd0, 32'd1);
    @(posedge i_clock); #1;
    i_lhs_valid = 1'b0;
  endtask

  task automatic push_rhs(input logic [W-1:0] d, output int waited);
    waited = 0;
    i_rhs_data  = d;
    i_rhs_valid = 1'b1;
    @(negedge i_clock);
    while (!o_rhs_ready && waited < 500) begin
      waited++;
      @(negedge i_clock);
    end
    if (!o_rhs_ready) check("rhs_timeout", 32'd0, 32'd1);
    @(posedge i_clock); #1;
    i_rhs_valid = 1'b0;
  endtask

  logic [W-1:0] sl[12];
  logic [W-1:0] sr[12];
  int           base, base_l, base_r, wt;

  initial begin
    sl[0] = 16'hFFFF; sr[0] = 16'h1001;
    sl[1] = 16'hF0F0; sr[1] = 16'h0110;
    sl[2] = 16'h0F0F; sr[2] = 16'h1616;
    sl[3] = 16'h8000; sr[3] = 16'hB00B;
    sl[4] = 16'h1234; sr[4] = 16'hAAAA;
    sl[5] = 16'h1101; sr[5] = 16'h0CDA;
    for (int i = 6; i < 12; i++) begin
      sl[i] = 16'($urandom);
      sr[i] = 16'($urandom);
    end

    // Reset values and first edge after release.
    repeat (3) @(posedge i_clock);
    @(negedge i_clock);
    check("rst_sum_valid", 32'(o_sum_valid), 32'd0);
    check("rst_sum_data", 32'(o_sum_data), 32'd0);
    check("rst_lhs_ready", 32'(o_lhs_ready), 32'd0);
    check("rst_rhs_ready", 32'(o_rhs_ready), 32'd0);
    @(posedge i_clock); #1;
    i_reset = 1'b0;
    @(posedge i_clock);
    @(negedge i_clock);
    check("post_rst_lhs_ready", 32'(o_lhs_ready), 32'd1);
    check("post_rst_rhs_ready", 32'(o_rhs_ready), 32'd1);

    // Idle.
    @(posedge i_clock); #1;
    base = n_out;
    i_sum_ready = 1'b1;
    phase = PH_IDLE;
    repeat (120) @(posedge i_clock);
    #1;
    phase = PH_OTHER;
    check("idle_outputs", 32'(n_out - base), 32'd0);
    check("idle_valid_seen", 32'(idle_valid_seen), 32'd0);

    // Streaming, both sides every cycle.
    base = n_out;
    stream_drop = 1'b0;
    phase = PH_STREAM;
    fork
      begin : st_l
        int wl;
        for (int i = 0; i < 12; i++) push_lhs(sl[i], wl);
      end
      begin : st_r
        int wr;
        for (int i = 0; i < 12; i++) push_rhs(sr[i], wr);
      end
      begin : st_lat
        @(posedge i_clock);
        @(negedge i_clock);
        check("latency_valid", 32'(o_sum_valid), 32'd1);
        check("first_sum", 32'(o_sum_data), 32'h0000EFFE);
      end
    join
    phase = PH_OTHER;
    repeat (3) @(posedge i_clock);
    #1;
    check("stream_outputs", 32'(n_out - base), 32'd12);
    check("stream_ready_drop", 32'(stream_drop), 32'd0);

    // Staggered one-cycle pulses, rhs first.
    base = n_out;
    i_sum_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      push_rhs((i == 0) ? 16'hC0DA : 16'($urandom), wt);
      check("stag_rhs_pulse", 32'(wt), 32'd0);
      push_lhs((i == 0) ? 16'h4321 : 16'($urandom), wt);
      check("stag_lhs_pulse", 32'(wt), 32'd0);
      if (i == 0) check("stag_first", 32'(o_sum_data), 32'h000083FB);
      i_sum_ready = 1'b1;
      @(posedge i_clock); #1;
      i_sum_ready = 1'b0;
    end
    i_sum_ready = 1'b1;
    repeat (3) @(posedge i_clock);
    #1;
    check("stag_outputs", 32'(n_out - base), 32'd12);

    // Back-pressure: output stalled for 5 cycles while both sides stream.
    base   = n_out;
    base_l = n_lacc;
    base_r = n_racc;
    fork
      begin : bp_l
        int wl;
        for (int i = 0; i < 6; i++) push_lhs(16'($urandom), wl);
      end
      begin : bp_r
        int wr;
        for (int i = 0; i < 6; i++) push_rhs(16'($urandom), wr);
      end
      begin : bp_ctl
        i_sum_ready = 1'b0;
        repeat (5) @(posedge i_clock);
        @(negedge i_clock);
        check("bp_lhs_ready", 32'(o_lhs_ready), 32'd0);
        check("bp_rhs_ready", 32'(o_rhs_ready), 32'd0);
        check("bp_lhs_accepted", 32'(n_lacc - base_l), 32'd2);
        check("bp_rhs_accepted", 32'(n_racc - base_r), 32'd2);
        @(posedge i_clock); #1;
        i_sum_ready = 1'b1;
      end
    join
    repeat (10) @(posedge i_clock);
    #1;
    check("bp_outputs", 32'(n_out - base), 32'd6);

    // Unbalanced: two lhs beats, rhs arrives later.
    base = n_out;
    fork
      begin : ub_l
        int wl;
        push_lhs(16'h1357, wl);
        push_lhs(16'h2468, wl);
      end
      begin : ub_r
        int wr;
        repeat (6) @(negedge i_clock);
        check("ub_lhs_ready", 32'(o_lhs_ready), 32'd0);
        check("ub_no_output", 32'(n_out - base), 32'd0);
        @(posedge i_clock); #1;
        push_rhs(16'hABCD, wr);
        push_rhs(16'h0F0F, wr);
      end
    join
    repeat (5) @(posedge i_clock);
    #1;
    check("ub_outputs", 32'(n_out - base), 32'd2);

    // Randomized traffic with random output stalls.
    for (int c = 0; c < 400; c++) begin
      @(posedge i_clock); #1;
      if (i_lhs_valid && l_x_last) i_lhs_valid = 1'b0;
      if (!i_lhs_valid && ($urandom_range(0, 2) != 0)) begin
        i_lhs_data  = 16'($urandom);
        i_lhs_valid = 1'b1;
      end
      if (i_rhs_valid && r_x_last) i_rhs_valid = 1'b0;
      if (!i_rhs_valid && ($urandom_range(0, 2) != 0)) begin
        i_rhs_data  = 16'($urandom);
        i_rhs_valid = 1'b1;
      end
      i_sum_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge i_clock); #1;
    i_lhs_valid = 1'b0;
    i_rhs_valid = 1'b0;
    i_sum_ready = 1'b1;
    repeat (20) @(posedge i_clock);
    #1;
    check("rand_pairs_pending", 32'((lq.size() < rq.size()) ? lq.size() : rq.size()), 32'd0);
    check("rand_drained_valid", 32'(o_sum_valid), 32'd0);

    // Clear any unpaired leftovers, then reset with buffered data.
    i_reset = 1'b1;
    repeat (2) @(posedge i_clock);
    #1;
    i_reset = 1'b0;
    @(posedge i_clock); #1;
    i_sum_ready = 1'b0;
    fork
      begin : rs_l
        int wl;
        push_lhs(16'h5A5A, wl);
        push_lhs(16'hA5A5, wl);
      end
      begin : rs_r
        int wr;
        push_rhs(16'h0001, wr);
        push_rhs(16'h8000, wr);
      end
    join
    i_reset = 1'b1;
    @(posedge i_clock);
    @(negedge i_clock);
    check("midrst_sum_valid", 32'(o_sum_valid), 32'd0);
    check("midrst_sum_data", 32'(o_sum_data), 32'd0);
    check("midrst_lhs_ready", 32'(o_lhs_ready), 32'd0);
    check("midrst_rhs_ready", 32'(o_rhs_ready), 32'd0);
    base = n_out;
    @(posedge i_clock); #1;
    i_reset = 1'b0;
    i_sum_ready = 1'b1;
    repeat (20) @(posedge i_clock);
    #1;
    check("midrst_no_stale", 32'(n_out - base), 32'd0);
    check("midrst_valid_low", 32'(o_sum_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_gf2.md
Name: adder_gf2

Overview:
Streaming GF(2) adder that joins two valid/ready operand streams (lhs, rhs) and emits their bitwise XOR on one valid/ready result stream. Each operand side is independently buffered, so operands may arrive in different cycles. Results are paired strictly in arrival order. Sits between producer pipelines in the datapath, for example in coding and checksum arithmetic.

Parameters:
WIDTH, 16, bit width of both operands and of the sum.

Ports:
i_clock  in  1  clock; all logic on the rising edge.
i_reset  in  1  synchronous, active-high reset.
i_lhs_data  in  WIDTH  left operand.
i_lhs_valid  in  1  left operand valid.
o_lhs_ready  out  1  left side can accept; registered.
i_rhs_data  in  WIDTH  right operand.
i_rhs_valid  in  1  right operand valid.
o_rhs_ready  out  1  right side can accept; registered.
o_sum_data  out  WIDTH  lhs XOR rhs; registered.
o_sum_valid  out  1  sum valid; registered.
i_sum_ready  in  1  downstream accepts the sum.

Behaviour:
- Interface: reset i_reset, synchronous, active-high; clock i_clock.
- Transfer on a port occurs when valid && ready at a rising edge.
- Reset values:
  - o_sum_valid=0, o_sum_data=0.
  - o_lhs_ready=0, o_rhs_ready=0.
  - Both skid registers empty.
- First edge after reset deasserts: both readys go to 1.
- Per side, a 2-slot skid stage (pass-through plus one skid register):
  - o_x_ready is registered and equals !skid_full (forced 0 in reset).
  - The side's head is the skid register if full, else the live input.
  - Head is valid if skid_full || (i_x_valid && o_x_ready).
  - An input transfer that is not consumed in the same cycle is captured into the skid register.
  - When the skid register is full and is consumed, it is cleared.
- Join: fire = lhs_head_valid && rhs_head_valid && (!o_sum_valid || i_sum_ready).
  - On fire, both heads are consumed in the same cycle.
  - o_sum_data <= lhs_head ^ rhs_head; o_sum_valid <= 1.
- Output register:
  - If o_sum_valid && i_sum_ready && !fire, then o_sum_valid <= 0.
  - Data holds stable while valid && !ready.
- Latency: both operands present at edge N gives the sum visible after edge N (one register stage).
- Throughput: 1 result per cycle when both inputs are valid every cycle and i_sum_ready=1. Readys stay 1 continuously in that case.
- One side early:
  - Its operand waits in the skid stage.
  - A one-cycle valid pulse on that side must be captured, since ready=1 whenever its skid register is empty.
  - At most 2 operands are outstanding per side: the head plus one more when ready was high.
- Back-pressure:
  - i_sum_ready=0 with o_sum_valid=1 stops fire.
  - Each side absorbs one more beat, then its ready drops.
  - No data is dropped or duplicated.
- Arithmetic: pure bitwise XOR, no carry, width WIDTH.
- Reset mid-operation: all buffered operands and any pending sum are discarded. Outputs return to their reset values on the next edge.
- Valid on either input with no partner never produces output.

Decomposition:
- No shared package needed. WIDTH is the only constant and is a parameter.
- One sub-module, gf2_skid_stage, parameterised by WIDTH, instantiated twice (lhs and rhs).
  - Ports: clock, reset, in data/valid/ready, head data/valid, consume.
- Join, XOR and output register are written in adder_gf2.

Test Plan:
- Idle: after reset, hold i_sum_ready=1, no valids for 100+ cycles -> zero output transfers; o_sum_valid stays 0.
- Streaming: 12 back-to-back pairs with both valids high and i_sum_ready=1, e.g. FFFF^1001, F0F0^0110, 0F0F^1616, 8000^B00B, 1234^AAAA, 1101^0CDA -> in order EFFE, F1E0, 1919, 300B, B89E, 1DDB; exactly 12 outputs; readys never drop.
- Staggered: per pair, rhs one-cycle pulse, lhs pulse 1 cycle later, i_sum_ready raised after -> 12 outputs total; e.g. 4321^C0DA -> 83FB.
- Back-pressure: stream pairs with i_sum_ready=0 for 5 cycles -> o_sum_data is held stable, each side accepts 1 extra beat then ready=0; after release all sums are delivered in order with no loss.
- Unbalanced: 2 lhs beats, no rhs -> second lhs ready low until rhs arrives; 0 outputs until then, then 2 correct sums.
- Reset mid-stream: assert i_reset with buffered data -> o_sum_valid=0 next edge; no stale sums are output after reset.
